// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC shadow register file: commit FSM states,
// default slot map and a constant clog2 helper.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } rtc_state_e;

  localparam int SLOT_SEC       = 0;
  localparam int SLOT_MIN       = 1;
  localparam int SLOT_HOUR      = 2;
  localparam int SLOT_DAY       = 3;
  localparam int SLOT_MON       = 4;
  localparam int SLOT_YEAR      = 5;
  localparam int SLOT_CHR_SEC   = 8;
  localparam int SLOT_CHR_MIN   = 9;
  localparam int SLOT_STAT_BASE = 10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rtc_shadow_ctrl.sv
// Commit sequencer for the shadow register file: window/commit FSM, copy
// index, write acceptance and the busy/commit_done/wr_drop indications.
module rtc_shadow_ctrl
  import rtc_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int COMMIT_N = 10,
  parameter int AW       = 4
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          win,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  output logic          wr_accept,
  output logic          commit_we,
  output logic [AW-1:0] commit_idx,
  output logic          rd_stg,
  output logic          busy,
  output logic          commit_done,
  output logic          wr_drop
);

  rtc_state_e    state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          drop_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      wr_drop <= drop_nxt;
    end
  end

  // Only the level of win seen in DONE decides where we go after a commit.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    unique case (state)
      ST_IDLE:   if (win) state_nxt = ST_WINDOW;
      ST_WINDOW: if (!win) begin
                   state_nxt = ST_COMMIT;
                   idx_nxt   = '0;
                 end
      ST_COMMIT: begin
                   idx_nxt = idx + 1'b1;
                   if (idx == AW'(COMMIT_N - 1)) state_nxt = ST_DONE;
                 end
      ST_DONE:   state_nxt = win ? ST_WINDOW : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == ST_COMMIT) || (state == ST_DONE);
    commit_done = (state == ST_DONE);
    commit_we   = (state == ST_COMMIT);
    commit_idx  = idx;
    rd_stg      = busy;
    wr_accept   = wr_en && !busy && (int'(wr_addr) < DEPTH);
    drop_nxt    = wr_en && !wr_accept;
  end

endmodule

// File: rtl/rtc_shadow_regfile.sv
// Double-buffered RTC register file: bus writes fill staging, a commit copies
// staging into live, and two registered read ports serve the display side.
module rtc_shadow_regfile
  import rtc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int COMMIT_N  = 10,
  parameter int STAT_BASE = SLOT_STAT_BASE,
  parameter int PTR_W     = 4,
  localparam int AW       = clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              win,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              stat_irq,
  input  logic [PTR_W-1:0]  stat_ptr,
  output logic              busy,
  output logic              commit_done,
  output logic              wr_drop
);

  logic [DATA_W-1:0] stg_mem  [DEPTH];
  logic [DATA_W-1:0] live_mem [DEPTH];

  logic              wr_accept;
  logic              commit_we;
  logic [AW-1:0]     commit_idx;
  logic              rd_stg;
  logic [DATA_W-1:0] irq_lo, irq_hi, ptr_w;
  logic [DATA_W-1:0] rd_a_p0, rd_b_p0;

  rtc_shadow_ctrl #(
    .DEPTH    (DEPTH),
    .COMMIT_N (COMMIT_N),
    .AW       (AW)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .win         (win),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_accept   (wr_accept),
    .commit_we   (commit_we),
    .commit_idx  (commit_idx),
    .rd_stg      (rd_stg),
    .busy        (busy),
    .commit_done (commit_done),
    .wr_drop     (wr_drop)
  );

  function automatic logic is_stat(input logic [AW-1:0] a);
    return (int'(a) >= STAT_BASE) && (int'(a) <= STAT_BASE + 2);
  endfunction

  always_comb begin
    irq_lo    = '0;
    irq_lo[0] = ~stat_irq;
    irq_hi    = '0;
    irq_hi[0] = stat_irq;
    ptr_w     = DATA_W'(stat_ptr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stg_mem[i] <= '0;
    end else if (wr_accept) begin
      stg_mem[wr_addr] <= wr_data;
    end
  end

  // Status slots are assigned last so they win over a commit copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) live_mem[i] <= '0;
    end else begin
      if (commit_we) live_mem[commit_idx] <= stg_mem[commit_idx];
      live_mem[STAT_BASE]     <= irq_lo;
      live_mem[STAT_BASE + 1] <= irq_hi;
      live_mem[STAT_BASE + 2] <= ptr_w;
    end
  end

  // p0: address decode and source select
  always_comb begin
    rd_a_p0 = '0;
    if (int'(rd_addr_a) < DEPTH) begin
      if (rd_stg && !is_stat(rd_addr_a)) rd_a_p0 = stg_mem[rd_addr_a];
      else                               rd_a_p0 = live_mem[rd_addr_a];
    end
  end

  always_comb begin
    rd_b_p0 = '0;
    if (int'(rd_addr_b) < DEPTH) begin
      if (rd_stg && !is_stat(rd_addr_b)) rd_b_p0 = stg_mem[rd_addr_b];
      else                               rd_b_p0 = live_mem[rd_addr_b];
    end
  end

  // p1: registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rd_a_p0;
      rd_data_b <= rd_b_p0;
    end
  end

endmodule

// File: tb/tb_rtc_shadow_regfile.sv
// Bench for rtc_shadow_regfile: directed scenarios plus random traffic, all
// outputs compared every cycle against a behavioural model of the register file.
module tb_rtc_shadow_regfile;

  localparam int NDEP   = 16;
  localparam int NDEP13 = 13;
  localparam int NCOMM  = 10;
  localparam int SB     = 10;
  localparam int PH_IDLE = 0, PH_WINDOW = 1, PH_COMMIT = 2, PH_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       win = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] rd_addr_a = '0;
  logic [3:0] rd_addr_b = '0;
  logic       stat_irq = 1'b0;
  logic [3:0] stat_ptr = '0;

  logic [7:0] rd_data_a, rd_data_b, rd_data_a13, rd_data_b13;
  logic       busy, commit_done, wr_drop;
  logic       busy13, commit_done13, wr_drop13;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // behavioural model
  logic [7:0] m_stg  [NDEP];
  logic [7:0] m_live [NDEP];
  int         m_phase = PH_IDLE;
  int         m_copied = 0;
  logic [7:0] e_rd_a = '0, e_rd_b = '0, e_rd_a13 = '0, e_rd_b13 = '0;
  logic       e_drop = 1'b0, e_drop13 = 1'b0;

  always #5 clk = ~clk;

  rtc_shadow_regfile dut (
    .clk(clk), .reset(reset), .win(win), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .stat_irq(stat_irq),
    .stat_ptr(stat_ptr), .busy(busy), .commit_done(commit_done), .wr_drop(wr_drop)
  );

  rtc_shadow_regfile #(.DEPTH(NDEP13)) dut13 (
    .clk(clk), .reset(reset), .win(win), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a13),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b13), .stat_irq(stat_irq),
    .stat_ptr(stat_ptr), .busy(busy13), .commit_done(commit_done13), .wr_drop(wr_drop13)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rdval(input int a, input int depth);
    if (a >= depth) return 8'h00;
    if (m_phase >= PH_COMMIT && !(a >= SB && a <= SB + 2)) return m_stg[a];
    return m_live[a];
  endfunction

  task automatic model_step();
    bit copying;
    if (reset) begin
      for (int i = 0; i < NDEP; i++) begin
        m_stg[i] = 8'h00;
        m_live[i] = 8'h00;
      end
      m_phase = PH_IDLE; m_copied = 0;
      e_rd_a = 0; e_rd_b = 0; e_rd_a13 = 0; e_rd_b13 = 0;
      e_drop = 0; e_drop13 = 0;
    end else begin
      e_rd_a   = rdval(int'(rd_addr_a), NDEP);
      e_rd_b   = rdval(int'(rd_addr_b), NDEP);
      e_rd_a13 = rdval(int'(rd_addr_a), NDEP13);
      e_rd_b13 = rdval(int'(rd_addr_b), NDEP13);
      copying  = (m_phase == PH_COMMIT);
      e_drop   = wr_en && copying || wr_en && (m_phase == PH_DONE);
      e_drop13 = e_drop || (wr_en && int'(wr_addr) >= NDEP13);
      if (copying) m_live[m_copied] = m_stg[m_copied];
      m_live[SB]     = {7'd0, ~stat_irq};
      m_live[SB + 1] = {7'd0, stat_irq};
      m_live[SB + 2] = {4'd0, stat_ptr};
      if (wr_en && !e_drop) m_stg[wr_addr] = wr_data;
      case (m_phase)
        PH_IDLE:   if (win) m_phase = PH_WINDOW;
        PH_WINDOW: if (!win) begin m_phase = PH_COMMIT; m_copied = 0; end
        PH_COMMIT: begin
                     m_copied++;
                     if (m_copied == NCOMM) m_phase = PH_DONE;
                   end
        default:   m_phase = win ? PH_WINDOW : PH_IDLE;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("rd_a", rd_data_a, e_rd_a);
    check("rd_b", rd_data_b, e_rd_b);
    check("busy", busy, m_phase >= PH_COMMIT);
    check("done", commit_done, m_phase == PH_DONE);
    check("drop", wr_drop, e_drop);
    check("rd_a13", rd_data_a13, e_rd_a13);
    check("rd_b13", rd_data_b13, e_rd_b13);
    check("busy13", busy13, m_phase >= PH_COMMIT);
    check("done13", commit_done13, m_phase == PH_DONE);
    check("drop13", wr_drop13, e_drop13);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_at;

    // reset, then sweep all addresses
    repeat (2) cycle();
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    for (int a = 0; a < NDEP; a++) begin
      rd_addr_a = 4'(a);
      rd_addr_b = 4'(NDEP - 1 - a);
      cycle();
    end
    rd_addr_a = 4'd10; rd_addr_b = 4'd5;
    cycle();
    check("rst_a10", rd_data_a, 8'h01);
    check("rst_b5", rd_data_b, 8'h00);

    // load staging in the window; live stays old
    win = 1'b1; cycle();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h59; rd_addr_a = 4'd0;
    cycle();
    check("win_rd_before_write", rd_data_a, 8'h00);
    wr_addr = 4'd2; wr_data = 8'h23;
    cycle();
    wr_en = 1'b0;
    cycle();
    check("win_rd_live_old", rd_data_a, 8'h00);
    win = 1'b0;
    cycle();

    // commit: timing, staging reads, dropped write, live status update
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    rd_addr_b = 4'd10;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cnt++;
      if (commit_done) begin done_cnt++; done_at = i; end
      if (i == 1) check("commit_drop", wr_drop, 1'b1);
      if (i == 3) check("commit_rd_stg", rd_data_a, 8'h59);
      if (i == 5) check("commit_stat10", rd_data_b, 8'h00);
      wr_en = (i == 0); wr_addr = 4'd3; wr_data = 8'hAA;
      if (i == 2) begin stat_irq = 1'b1; stat_ptr = 4'd7; end
      cycle();
    end
    check("busy_cycles", busy_cnt, 11);
    check("done_pulses", done_cnt, 1);
    check("done_offset", done_at, 10);
    rd_addr_a = 4'd0; rd_addr_b = 4'd2; cycle();
    check("live_addr0", rd_data_a, 8'h59);
    check("live_addr2", rd_data_b, 8'h23);
    rd_addr_a = 4'd3; rd_addr_b = 4'd12; cycle();
    check("live_addr3_untouched", rd_data_a, 8'h00);
    check("live_ptr", rd_data_b, 8'h07);
    rd_addr_a = 4'd11; rd_addr_b = 4'd10; cycle();
    check("live_irq", rd_data_a, 8'h01);
    check("live_irq_n", rd_data_b, 8'h00);

    // out-of-range write on the 13-deep instance
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 8'h33;
    cycle();
    wr_en = 1'b0;
    check("oor_drop13", wr_drop13, 1'b1);
    check("inrange_nodrop", wr_drop, 1'b0);
    rd_addr_a = 4'd13; cycle();
    check("oor_rd13", rd_data_a13, 8'h00);

    // reset in the middle of a commit
    win = 1'b1; cycle();
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h42; cycle();
    wr_en = 1'b0; win = 1'b0; cycle();
    repeat (4) cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    rd_addr_a = 4'd1; rd_addr_b = 4'd0; cycle();
    check("abort_rd1", rd_data_a, 8'h00);
    check("abort_rd0", rd_data_b, 8'h00);
    repeat (2) cycle();
    check("abort_idle", busy, 1'b0);

    // win held high through DONE returns to WINDOW
    win = 1'b1; cycle();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h12; cycle();
    wr_en = 1'b0; win = 1'b0; cycle();
    win = 1'b1;
    for (int i = 0; i < 20 && !commit_done; i++) cycle();
    check("done_seen", commit_done, 1'b1);
    cycle();
    check("back_in_window", busy, 1'b0);
    win = 1'b0; cycle();
    check("recommit_from_window", busy, 1'b1);
    repeat (12) cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) win = ~win;
      wr_en = ($urandom_range(0, 2) == 0);
      wr_addr = 4'($urandom);
      wr_data = 8'($urandom);
      rd_addr_a = 4'($urandom);
      rd_addr_b = 4'($urandom);
      stat_irq = 1'($urandom);
      if ($urandom_range(0, 15) == 0) stat_ptr = 4'($urandom);
      cycle();
    end
    reset = 1'b0; wr_en = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
